// File: rtl/tv_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tv_capture
//  Purpose  : Samples live {A, B, Y} stimulus/response tuples from a running
//             DUT. Each tuple is packed into one test-vector word with A in
//             the MSBs, then B, then Y in the LSBs. Words are buffered in a
//             small FIFO and streamed out over a valid/ready interface. A run
//             stops after NUM_VECTORS accepted vectors. The FIFO then drains,
//             and the block reports done.
//
//  Ports    : clk        in   rising-edge clock
//             reset      in   synchronous, active-low reset
//             start      in   one-cycle pulse; begins a run from IDLE/DONE
//             sample_en  in   capture a_in/b_in/y_in this cycle
//             a_in       in   [A_W]  stimulus A
//             b_in       in   [B_W]  stimulus B
//             y_in       in   [Y_W]  DUT response Y
//             tv_data    out  [A_W+B_W+Y_W]  packed vector {A,B,Y}
//             tv_valid   out  tv_data holds an unread vector
//             tv_ready   in   downstream accepts tv_data
//             busy       out  run in progress (CAPTURE or DRAIN)
//             done       out  run complete and FIFO drained
//             overflow   out  sticky; a sample was dropped on a full FIFO
//             count      out  [8] vectors accepted this run
//
//  Options  : TV_CAPTURE_DEDUP_EN. When defined, a sample identical to the
//             last accepted vector of the current run is silently discarded.
//
//  Revision : 1.0  initial release
// ============================================================================
module tv_capture #(
  parameter int A_W         = 8,
  parameter int B_W         = 4,
  parameter int Y_W         = 8,
  parameter int DEPTH       = 16,
  parameter int NUM_VECTORS = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     sample_en,
  input  logic [A_W-1:0]           a_in,
  input  logic [B_W-1:0]           b_in,
  input  logic [Y_W-1:0]           y_in,
  output logic [A_W+B_W+Y_W-1:0]   tv_data,
  output logic                     tv_valid,
  input  logic                     tv_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [7:0]               count
);

  localparam int                 c_VEC_W   = A_W + B_W + Y_W;
  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam logic [7:0]         c_NUM     = 8'(NUM_VECTORS);
  localparam logic [c_PTR_W:0]   c_PTR_ONE = (c_PTR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_PTR_W:0]     r_wr_ptr;
  logic [c_PTR_W:0]     r_rd_ptr;
  logic [c_VEC_W-1:0]   r_mem [DEPTH];
  logic [7:0]           r_count;
  logic                 r_overflow;
  logic                 r_busy;
  logic                 r_done;

  logic [c_VEC_W-1:0]   w_vec;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_start;
  logic                 w_take;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_dup;

  assign w_vec = {a_in, b_in, y_in};

  // Pointers carry one extra wrap bit. Equal pointers mean empty. Equal
  // indices with differing wrap bits mean full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

  // start is only honoured when no run is in progress.
  assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // A qualifying sample either pushes, or is dropped with overflow. The full
  // test uses pre-edge occupancy, so a same-cycle pop cannot make room.
  assign w_take = (r_state == S_CAPTURE) && sample_en && !w_dup;
  assign w_push = w_take && !w_full;
  assign w_pop  = tv_valid && tv_ready;

`ifdef TV_CAPTURE_DEDUP_EN
  logic [c_VEC_W-1:0]   r_last;
  logic                 r_last_vld;

  assign w_dup = r_last_vld && (w_vec == r_last);

  // Tracks the most recent vector that actually entered the FIFO. Invalidating
  // it on start guarantees the first sample of a run is always accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_vld <= 1'b0;
      r_last     <= '0;
    end else if (w_start) begin
      r_last_vld <= 1'b0;
    end else if (w_push) begin
      r_last     <= w_vec;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // Storage array, deliberately left without reset. Unread entries are never
  // exposed because tv_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_vec;
    end
  end

  // Control FSM, FIFO pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_start) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state    <= S_CAPTURE;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (w_push) begin
            r_count <= r_count + 8'd1;
            // Once the final vector is accepted, further samples are ignored.
            // This keeps count saturated at NUM_VECTORS.
            if ((r_count + 8'd1) == c_NUM) begin
              r_state <= S_DRAIN;
            end
          end else if (w_take) begin
            r_overflow <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign tv_valid = !w_empty;
  assign tv_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_PTR_W-1:0]];
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_tv_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tv_capture
//  Purpose  : Directed self-checking bench for tv_capture at default
//             parameters. It covers reset, a basic run, backpressure and a
//             full FIFO, restart, reset mid-run, and duplicate samples.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tv_capture;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        sample_en = 1'b0;
  logic [7:0]  a_in      = '0;
  logic [3:0]  b_in      = '0;
  logic [7:0]  y_in      = '0;
  logic        tv_ready  = 1'b0;
  logic [19:0] tv_data;
  logic        tv_valid;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [7:0]  count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] got[$];
  logic [19:0] exp_q[$];
  logic [7:0]  ta;
  logic [3:0]  tb;
  logic [7:0]  ty;

  tv_capture #(
    .A_W(8), .B_W(4), .Y_W(8), .DEPTH(16), .NUM_VECTORS(50)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
    .a_in(a_in), .b_in(b_in), .y_in(y_in),
    .tv_data(tv_data), .tv_valid(tv_valid), .tv_ready(tv_ready),
    .busy(busy), .done(done), .overflow(overflow), .count(count)
  );

  initial forever #5 clk = ~clk;

  // Inputs change #1 after posedge, so at negedge they equal the values the
  // next posedge will see. A transfer seen here is the pop at that edge.
  always @(negedge clk) begin
    if (reset && tv_valid && tv_ready) got.push_back(tv_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic samp(input logic [7:0] a, input logic [3:0] b, input logic [7:0] y);
    sample_en = 1'b1;
    a_in = a;
    b_in = b;
    y_in = y;
    step();
    sample_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      step();
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), {12'd0, got[i]}, {12'd0, exp_q[i]});
  endtask

  initial begin
    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_valid", {31'd0, tv_valid}, 32'd0);
    chk("rst_data", {12'd0, tv_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);

    // ---------------- basic run ----------------
    reset = 1'b1;
    tv_ready = 1'b1;
    pulse_start();
    chk("basic_busy0", {31'd0, busy}, 32'd1);
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 50; i++) begin
      ta = 8'(i);
      tb = ta[3:0];
      ty = ta + {4'd0, tb};
      exp_q.push_back({ta, tb, ty});
      samp(ta, tb, ty);
    end
    chk("basic_count", {24'd0, count}, 32'd50);
    chk("basic_busy1", {31'd0, busy}, 32'd1);
    step();  // last pop happens at this edge
    chk("basic_done_early", {31'd0, done}, 32'd0);
    chk("basic_valid_empty", {31'd0, tv_valid}, 32'd0);
    step();
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_busy_end", {31'd0, busy}, 32'd0);
    chk("basic_ovf", {31'd0, overflow}, 32'd0);
    chk("basic_word0", {12'd0, (got.size() > 0) ? got[0] : 20'hFFFFF}, 32'h00000);
    chk("basic_word5", {12'd0, (got.size() > 5) ? got[5] : 20'hFFFFF}, 32'h0550A);
    chk_stream("basic");

    // ---------------- restart from DONE with backpressure ----------------
    tv_ready = 1'b0;
    got.delete();
    exp_q.delete();
    pulse_start();
    chk("rs1_done", {31'd0, done}, 32'd0);
    chk("rs1_busy", {31'd0, busy}, 32'd1);
    chk("rs1_count", {24'd0, count}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      ta = 8'h20 + 8'(i);
      tb = ta[3:0];
      ty = 8'h40 + 8'(i);
      exp_q.push_back({ta, tb, ty});
      samp(ta, tb, ty);
      if (i == 0) begin
        chk("bp_valid_first", {31'd0, tv_valid}, 32'd1);
        chk("bp_data_first", {12'd0, tv_data}, {12'd0, exp_q[0]});
      end
    end
    chk("bp_count16", {24'd0, count}, 32'd16);
    chk("bp_ovf_before", {31'd0, overflow}, 32'd0);
    chk("bp_data_hold", {12'd0, tv_data}, {12'd0, exp_q[0]});
    samp(8'hFF, 4'h0, 8'h00);  // dropped: FIFO full
    chk("bp_ovf", {31'd0, overflow}, 32'd1);
    chk("bp_count_drop", {24'd0, count}, 32'd16);
    chk("bp_valid_hold", {31'd0, tv_valid}, 32'd1);
    chk("bp_data_hold2", {12'd0, tv_data}, {12'd0, exp_q[0]});

    // Full plus a same-cycle pop: the sample is still rejected.
    tv_ready = 1'b1;
    samp(8'hFE, 4'h1, 8'h01);
    chk("fp_ovf", {31'd0, overflow}, 32'd1);
    chk("fp_count", {24'd0, count}, 32'd16);
    for (int i = 0; i < 20; i++) step();
    chk("fp_drained", {31'd0, tv_valid}, 32'd0);
    chk_stream("bp");

    // Finish this run; overflow must persist to DONE.
    for (int i = 0; i < 34; i++) begin
      ta = 8'h80 + 8'(i);
      tb = ta[3:0];
      ty = 8'hC0 + 8'(i);
      exp_q.push_back({ta, tb, ty});
      samp(ta, tb, ty);
    end
    wait_done();
    chk("bprun_count", {24'd0, count}, 32'd50);
    chk("bprun_ovf", {31'd0, overflow}, 32'd1);
    chk_stream("bprun");

    // ---------------- restart clears overflow ----------------
    got.delete();
    exp_q.delete();
    pulse_start();
    chk("rs2_done", {31'd0, done}, 32'd0);
    chk("rs2_busy", {31'd0, busy}, 32'd1);
    chk("rs2_count", {24'd0, count}, 32'd0);
    chk("rs2_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      ta = 8'hA5 ^ 8'(i);
      tb = ta[3:0];
      ty = ~8'(i);
      exp_q.push_back({ta, tb, ty});
      samp(ta, tb, ty);
    end
    wait_done();
    chk("rs2_count_end", {24'd0, count}, 32'd50);
    chk("rs2_ovf_end", {31'd0, overflow}, 32'd0);
    chk_stream("rs2");

    // ---------------- reset mid-run ----------------
    tv_ready = 1'b0;
    got.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) samp(8'(i) + 8'h30, 4'(i), 8'(i));
    tv_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    tv_ready = 1'b0;
    chk("mid_count", {24'd0, count}, 32'd10);
    chk("mid_valid", {31'd0, tv_valid}, 32'd1);
    chk("mid_popped", got.size(), 32'd6);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_valid", {31'd0, tv_valid}, 32'd0);
    chk("mid_rst_data", {12'd0, tv_data}, 32'd0);
    chk("mid_rst_count", {24'd0, count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    got.delete();
    tv_ready = 1'b1;
    for (int i = 0; i < 5; i++) samp(8'h77, 4'h7, 8'(i));
    step();
    chk("idle_no_out", got.size(), 32'd0);
    chk("idle_valid", {31'd0, tv_valid}, 32'd0);
    chk("idle_count", {24'd0, count}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // ---------------- duplicate samples ----------------
    got.delete();
    exp_q.delete();
    pulse_start();
    samp(8'h12, 4'h3, 8'h15);
    samp(8'h12, 4'h3, 8'h15);
    samp(8'h12, 4'h3, 8'h15);
    samp(8'h13, 4'h3, 8'h16);
    for (int i = 0; i < 4; i++) step();
`ifdef TV_CAPTURE_DEDUP_EN
    exp_q.push_back(20'h12315);
    exp_q.push_back(20'h13316);
    chk("dedup_count", {24'd0, count}, 32'd2);
`else
    exp_q.push_back(20'h12315);
    exp_q.push_back(20'h12315);
    exp_q.push_back(20'h12315);
    exp_q.push_back(20'h13316);
    chk("dedup_count", {24'd0, count}, 32'd4);
`endif
    chk("dedup_ovf", {31'd0, overflow}, 32'd0);
    chk_stream("dedup");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tv_capture.md
Name: tv_capture

Overview:
- Writer-side counterpart to the vector-driven self-checking benches.
- Samples live stimulus/response tuples {A, B, Y} from a running DUT and packs each into one test-vector word. The bit layout is identical to the bench's vector file: A in the MSBs, then B, then Y in the LSBs.
- Buffers words in a small FIFO and streams them out over a valid/ready interface for dumping to a vector file or checker.
- A capture run stops after a fixed vector count, so the result mirrors a fixed-length vector file.

Parameters:
- A_W, 8, width of stimulus A
- B_W, 4, width of stimulus B
- Y_W, 8, width of response Y
- DEPTH, 16, FIFO entries; power of 2, minimum 2
- NUM_VECTORS, 50, vectors per run; range 1..255

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-low
- start  in  1  single-cycle pulse; begins a capture run
- sample_en  in  1  capture a_in/b_in/y_in this cycle
- a_in  in  A_W  stimulus A
- b_in  in  B_W  stimulus B
- y_in  in  Y_W  DUT response Y
- tv_data  out  A_W+B_W+Y_W  packed vector {A,B,Y}; 20 bits at defaults
- tv_valid  out  1  tv_data holds an unread vector
- tv_ready  in  1  downstream accepts tv_data
- busy  out  1  run in progress (CAPTURE or DRAIN)
- done  out  1  run complete and FIFO drained
- overflow  out  1  sticky; a sample was dropped because the FIFO was full
- count  out  8  vectors accepted into the FIFO this run

Behaviour:
- Reset (reset=0 at a clk edge):
  - FSM goes to IDLE; FIFO is emptied; count=0.
  - tv_valid=0, tv_data=0, busy=0, done=0, overflow=0.
  - Reset mid-run discards all buffered vectors.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - start=1 -> CAPTURE; count, overflow and FIFO are cleared in the same edge.
  - sample_en is ignored.
- CAPTURE:
  - sample_en=1 and FIFO not full -> push {a_in,b_in,y_in}; count++.
  - sample_en=1 and FIFO full -> sample dropped; overflow set; count unchanged.
  - The full test uses the pre-edge occupancy: a push is rejected when full even if a pop happens in the same cycle.
  - When a push makes count==NUM_VECTORS -> DRAIN. Later sample_en pulses are ignored.
  - start is ignored.
- DRAIN: FIFO empty -> DONE.
- DONE:
  - done=1 and busy=0.
  - start=1 -> CAPTURE with the same clearing as from IDLE. done drops on that edge.
- busy = state is CAPTURE or DRAIN.
- Output stream:
  - tv_valid = FIFO not empty; tv_data = FIFO head.
  - Pop occurs when tv_valid && tv_ready at the edge.
  - tv_data and tv_valid must hold stable while tv_valid=1 and tv_ready=0.
  - Latency: a sample accepted at edge k into an empty FIFO gives tv_valid=1 and tv_data=vector after edge k.
  - Order is strictly FIFO.
- Simultaneous push and pop, FIFO not full: both occur and occupancy is unchanged.
- FIFO pointers are log2(DEPTH) bits wide plus one wrap bit for full/empty detection. They wrap modulo DEPTH.
- count saturates at NUM_VECTORS and never exceeds it.
- overflow clears only on reset or start.

Optional Feature:
- Macro: TV_CAPTURE_DEDUP_EN.
- Defined:
  - A sample whose {a_in,b_in,y_in} equals the last accepted vector of the current run is discarded.
  - A discarded sample is not pushed, does not change count, and does not set overflow, even if the FIFO is full.
  - The last-vector register is invalidated on reset and on start, so the first sample of a run is always accepted.
- Not defined: every qualifying sample_en is captured, with no comparison logic.

Test Plan:
- Basic run (defaults): reset, then start; 50 sample_en pulses with A=i, B=i[3:0], Y=A+B; tv_ready=1 throughout.
  -> 50 words in order, word 0 = 20'h00000, word 5 = {8'h05,4'h5,8'h0A}; count=50; done=1 one cycle after the last pop; overflow=0.
- Backpressure: tv_ready=0 with 16 samples pushed, then a 17th sample (A=8'hFF).
  -> tv_valid stays 1 with tv_data frozen at the first vector; the 17th sample is dropped; overflow=1; count=16.
  -> When tv_ready rises, exactly 16 words emerge.
- Full plus simultaneous pop: FIFO full, sample_en and tv_ready both 1 in the same cycle.
  -> Sample rejected; overflow=1; occupancy becomes 15.
- Reset mid-run: reset=0 after 10 vectors with 4 unread.
  -> Next cycle: tv_valid=0, count=0, busy=0, done=0.
  -> sample_en with no start produces no output.
- Restart from DONE: start pulse after done=1.
  -> done=0, busy=1, count=0, overflow=0; a new 50-vector run completes normally.
- Dedup (TV_CAPTURE_DEDUP_EN defined): three identical samples {8'h12,4'h3,8'h15}, then {8'h13,4'h3,8'h16}.
  -> Exactly 2 words output; count=2.
  -> Without the macro: 4 words; count=4.
